dso_trig_capture: RTL and testbench
===================================

# dso_trig_capture

Single-clock trigger, decimation and capture core for the oscilloscope path. It sits between the ADC sample stream and the DSO register slave. The slave supplies the control fields (wave_run, trig_level, trig_edge, h_shift, deci_rate, ram_refresh), and this block returns wave_rd_data for the 1024-byte waveform window. Each capture writes decimated samples into a circular buffer around a level/edge trigger and presents them trigger-aligned on a registered read port.

## Interface
- DEPTH_LOG2, 10, log2 of buffer depth; DEPTH = 1024.
- PRE_TRIG, 512, number of samples retained before the trigger sample; must be < DEPTH.
- clk  in  1  sole clock; ad_valid is a strobe in this domain.
- rst  in  1  synchronous reset, active-high.
- ad_valid  in  1  one ADC sample present this cycle.
- ad_data  in  8  unsigned sample.
- wave_run  in  1  enable; 0 forces IDLE.
- trig_level  in  8  trigger threshold, unsigned.
- trig_edge  in  1  1 = rising, 0 = falling.
- h_shift  in  10  read-window offset, modulo DEPTH.
- deci_rate  in  10  keep one of every max(deci_rate,1) valid samples.
- ram_refresh  in  1  capture request; acted on at rising edge only.
- wave_rd_addr  in  10  logical read index 0..1023.
- wave_rd_data  out  8  registered read data.
- capture_done  out  1  buffer holds a complete triggered capture.
- capture_busy  out  1  state is PRETRIG, ARMED or POST.

## Operation
- States: IDLE, PRETRIG, ARMED, POST, DONE.
- Start condition:
  - IDLE→PRETRIG or DONE→PRETRIG on a ram_refresh 0→1 edge while wave_run=1.
  - Entry clears capture_done, resets wr_ptr to 0, the decimation counter to 0, the pre-count to 0 and prev_valid.
  - ram_refresh edges while busy are ignored.
- Decimation: each accepted ad_valid increments the counter. The sample is kept when counter reaches max(deci_rate,1)-1, and the counter then returns to 0. deci_rate 0 and 1 both keep every sample.
- Every kept sample is written at wr_ptr, after which wr_ptr increments modulo DEPTH.
- PRETRIG: count kept samples. After PRE_TRIG kept samples, go to ARMED. No trigger evaluation occurs in this state.
- ARMED: trigger evaluation on kept samples, where prev is the previous kept sample.
  - Rising: prev < trig_level and cur >= trig_level.
  - Falling: prev >= trig_level and cur < trig_level.
  - The first kept sample after entry sets prev only.
  - On a hit: trig_ptr ← wr_ptr of the triggering sample, post-count ← 1, go to POST.
  - No timeout: ARMED waits indefinitely.
- POST: kept samples increment post-count. When post-count reaches DEPTH-PRE_TRIG, go to DONE and set capture_done.
- DONE: no writes occur. The buffer is frozen until the next start condition.
- wave_run=0 in any state: IDLE next cycle, capture_done←0. Buffer contents are retained but not marked valid.
- Read mapping: physical address = trig_ptr − PRE_TRIG + h_shift + wave_rd_addr, all modulo DEPTH (10-bit wrap arithmetic).
- Reads are permitted in every state. Outside DONE the returned data is raw buffer content.
- A read and a write to the same physical address in the same cycle returns the old value (read-first).

## Timing
- Reset values: state IDLE, wave_rd_data 0x00, capture_done 0, capture_busy 0. trig_ptr, wr_ptr and all counters are 0, and ram_refresh edge history is 0.
- Buffer contents are not reset.
- Read latency is 1 cycle: wave_rd_addr sampled at edge N produces wave_rd_data after edge N+1. The slave's one-cycle valid delay relies on this.
- Buffer write latency is 0: a kept sample is written at the same edge it is kept.
- State transitions take effect at the edge where the condition is seen:
  - capture_done rises at the edge that writes the final POST sample.
  - capture_busy mirrors the state combinationally from registered state.
- Capture length: exactly DEPTH kept samples from start to DONE when the trigger fires immediately after PRETRIG.
- Control inputs are sampled every cycle. Changing deci_rate mid-capture applies at the next counter compare.
- Asserting rst mid-capture aborts the capture: IDLE, with outputs at their reset values on the next cycle.

## Structure
- Shared package dso_pkg holds:
  - the state enum for the five states;
  - DSO_DEPTH_LOG2 = 10 and DSO_PRE_TRIG = 512 defaults;
  - the edge encoding constants (EDGE_FALL = 0, EDGE_RISE = 1).
- One sub-module, dso_wave_ram: simple dual-port DEPTH×8, one write port, read-first registered read port, no reset on the array.
- Control FSM, decimator, trigger compare and address arithmetic live in dso_trig_capture.

## Test plan
- Ramp 0..255 repeating, deci_rate=1, level 100, rising, refresh pulse. Expected:
  - capture_done after exactly 1024 kept samples;
  - reading addr 512 returns 100 and addr 511 returns 99;
  - h_shift=1 makes addr 511 return 100.
- Same ramp, falling edge at level 100: no trigger until the ramp wraps 255→0. Expected: addr 512 returns 0 and addr 511 returns 255.
- deci_rate=4 on a 0,1,2,… counter stream. Expected: kept samples are 3,7,11,…, consecutive read addresses differ by 4, and deci_rate=0 behaves as 1.
- wave_run dropped during ARMED. Expected: IDLE next cycle, capture_done=0, and a later refresh edge restarts from PRETRIG.
- Second ram_refresh edge during POST is ignored. A refresh in DONE clears capture_done on the next cycle and recaptures.
- rst asserted in POST. Expected: next cycle shows wave_rd_data=0, capture_done=0 and capture_busy=0, and no writes occur until a new refresh edge.

Source files
------------

// File: rtl/dso_pkg.sv
// Shared definitions for the oscilloscope trigger/capture path:
// capture states, default geometry and trigger edge encoding.
package dso_pkg;

    localparam int DSO_DEPTH_LOG2 = 10;
    localparam int DSO_PRE_TRIG   = 512;

    localparam logic EDGE_FALL = 1'b0;
    localparam logic EDGE_RISE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRETRIG,
        ST_ARMED,
        ST_POST,
        ST_DONE
    } dso_state_e;

endpackage

// File: rtl/dso_wave_ram.sv
// Simple dual-port waveform buffer: one write port, one registered
// read-first read port. Only the read register is reset.
module dso_wave_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];
    logic [DATA_W-1:0] rd_data_q;

    // NOTE: the array has no reset so it maps onto block RAM; clearing it would need a sweep.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking update gives read-first behaviour on a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/dso_trig_capture.sv
// Trigger, decimation and capture core: writes decimated ADC samples into a
// circular buffer around a level/edge trigger and reads them back trigger-aligned.
module dso_trig_capture
    import dso_pkg::*;
#(
    parameter int DEPTH_LOG2 = DSO_DEPTH_LOG2,
    parameter int PRE_TRIG   = DSO_PRE_TRIG
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ad_valid,
    input  logic [7:0]            ad_data,
    input  logic                  wave_run,
    input  logic [7:0]            trig_level,
    input  logic                  trig_edge,
    input  logic [DEPTH_LOG2-1:0] h_shift,
    input  logic [9:0]            deci_rate,
    input  logic                  ram_refresh,
    input  logic [DEPTH_LOG2-1:0] wave_rd_addr,
    output logic [7:0]            wave_rd_data,
    output logic                  capture_done,
    output logic                  capture_busy
);

    localparam int DEPTH    = 1 << DEPTH_LOG2;
    localparam int POST_LEN = DEPTH - PRE_TRIG;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   post_t;

    localparam ptr_t  PRE_OFF   = ptr_t'(PRE_TRIG);
    localparam ptr_t  PRE_LAST  = ptr_t'(PRE_TRIG - 1);
    localparam post_t POST_LAST = post_t'(POST_LEN - 1);

    dso_state_e state_q, state_d;
    logic       refresh_prev_q, refresh_prev_d;
    logic       done_q, done_d;
    ptr_t       wr_ptr_q, wr_ptr_d;
    ptr_t       trig_ptr_q, trig_ptr_d;
    logic [9:0] deci_cnt_q, deci_cnt_d;
    ptr_t       pre_cnt_q, pre_cnt_d;
    post_t      post_cnt_q, post_cnt_d;
    logic [7:0] prev_q, prev_d;
    logic       prev_valid_q, prev_valid_d;

    logic       refresh_rise;
    logic       start;
    logic       accept;
    logic       keep;
    logic       hit;
    logic       wr_en;
    logic [9:0] deci_last;
    ptr_t       rd_addr;

    always_comb begin
        deci_last    = (deci_rate == 10'd0) ? 10'd0 : deci_rate - 10'd1;
        refresh_rise = ram_refresh & ~refresh_prev_q;
        capture_busy = (state_q == ST_PRETRIG) || (state_q == ST_ARMED) || (state_q == ST_POST);
        start        = wave_run && refresh_rise && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        accept       = capture_busy && wave_run && ad_valid;
        // >= rather than == so a mid-capture drop of deci_rate cannot strand the counter.
        keep         = accept && (deci_cnt_q >= deci_last);
        if (trig_edge == EDGE_RISE) begin
            hit = prev_valid_q && (prev_q < trig_level) && (ad_data >= trig_level);
        end else begin
            hit = prev_valid_q && (prev_q >= trig_level) && (ad_data < trig_level);
        end
    end

    // NOTE: every *_d gets its hold value first, so no path through the case can infer a latch.
    always_comb begin
        state_d        = state_q;
        refresh_prev_d = ram_refresh;
        done_d         = done_q;
        wr_ptr_d       = wr_ptr_q;
        trig_ptr_d     = trig_ptr_q;
        deci_cnt_d     = deci_cnt_q;
        pre_cnt_d      = pre_cnt_q;
        post_cnt_d     = post_cnt_q;
        prev_d         = prev_q;
        prev_valid_d   = prev_valid_q;

        if (accept) begin
            deci_cnt_d = keep ? 10'd0 : deci_cnt_q + 10'd1;
        end
        if (keep) begin
            wr_ptr_d     = wr_ptr_q + ptr_t'(1);
            prev_d       = ad_data;
            prev_valid_d = 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = (PRE_TRIG == 0) ? ST_ARMED : ST_PRETRIG;
                    done_d       = 1'b0;
                    wr_ptr_d     = '0;
                    deci_cnt_d   = '0;
                    pre_cnt_d    = '0;
                    prev_valid_d = 1'b0;
                end
            end
            ST_PRETRIG: begin
                if (keep) begin
                    pre_cnt_d = pre_cnt_q + ptr_t'(1);
                    if (pre_cnt_q == PRE_LAST) begin
                        state_d = ST_ARMED;
                    end
                end
            end
            ST_ARMED: begin
                if (keep && hit) begin
                    trig_ptr_d = wr_ptr_q;
                    post_cnt_d = post_t'(1);
                    if (POST_LEN == 1) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_POST;
                    end
                end
            end
            ST_POST: begin
                if (keep) begin
                    post_cnt_d = post_cnt_q + post_t'(1);
                    if (post_cnt_q == POST_LAST) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!wave_run) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            refresh_prev_q <= 1'b0;
            done_q         <= 1'b0;
            wr_ptr_q       <= '0;
            trig_ptr_q     <= '0;
            deci_cnt_q     <= '0;
            pre_cnt_q      <= '0;
            post_cnt_q     <= '0;
            prev_q         <= '0;
            prev_valid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            refresh_prev_q <= refresh_prev_d;
            done_q         <= done_d;
            wr_ptr_q       <= wr_ptr_d;
            trig_ptr_q     <= trig_ptr_d;
            deci_cnt_q     <= deci_cnt_d;
            pre_cnt_q      <= pre_cnt_d;
            post_cnt_q     <= post_cnt_d;
            prev_q         <= prev_d;
            prev_valid_q   <= prev_valid_d;
        end
    end

    // Logical index 0 lands PRE_TRIG samples before the trigger sample.
    assign rd_addr      = trig_ptr_q - PRE_OFF + h_shift + wave_rd_addr;
    assign wr_en        = keep && !rst;
    assign capture_done = done_q;

    dso_wave_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (8)
    ) u_wave_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (ad_data),
        .rd_addr (rd_addr),
        .rd_data (wave_rd_data)
    );

endmodule

// File: tb/tb_dso_trig_capture.sv
// Randomized scoreboard bench for dso_trig_capture: a kept-sample list model
// predicts completion timing and trigger-aligned read data.
module tb_dso_trig_capture;

    localparam int DEPTH    = 1024;
    localparam int PRE_TRIG = 512;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ad_valid = 1'b0;
    logic [7:0] ad_data = 8'd0;
    logic       wave_run = 1'b0;
    logic [7:0] trig_level = 8'd0;
    logic       trig_edge = 1'b0;
    logic [9:0] h_shift = 10'd0;
    logic [9:0] deci_rate = 10'd0;
    logic       ram_refresh = 1'b0;
    logic [9:0] wave_rd_addr = 10'd0;
    logic [7:0] wave_rd_data;
    logic       capture_done;
    logic       capture_busy;

    always #5 clk = ~clk;

    dso_trig_capture #(
        .DEPTH_LOG2 (10),
        .PRE_TRIG   (PRE_TRIG)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ad_valid     (ad_valid),
        .ad_data      (ad_data),
        .wave_run     (wave_run),
        .trig_level   (trig_level),
        .trig_edge    (trig_edge),
        .h_shift      (h_shift),
        .deci_rate    (deci_rate),
        .ram_refresh  (ram_refresh),
        .wave_rd_addr (wave_rd_addr),
        .wave_rd_data (wave_rd_data),
        .capture_done (capture_done),
        .capture_busy (capture_busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model: list of kept samples ----------------
    logic [7:0] kept[$];
    int         vcount;
    int         rkeep;
    int         trig_idx;
    int         cfg_level;
    logic       cfg_edge;
    bit         trig_found;
    int         data_n;

    function automatic bit is_hit(input int p, input int c);
        if (cfg_edge) return (p < cfg_level) && (c >= cfg_level);
        return (p >= cfg_level) && (c < cfg_level);
    endfunction

    function automatic bit model_done();
        return trig_found && (kept.size() == trig_idx + DEPTH - PRE_TRIG);
    endfunction

    task automatic model_push(input logic [7:0] d);
        vcount++;
        if (vcount % rkeep == 0) begin
            kept.push_back(d);
            if (!trig_found && kept.size() > PRE_TRIG &&
                is_hit(int'(kept[kept.size() - 2]), int'(kept[kept.size() - 1]))) begin
                trig_found = 1'b1;
                trig_idx   = kept.size() - 1;
            end
        end
    endtask

    function automatic logic [7:0] exp_read(input int a, input int h);
        return kept[trig_idx - PRE_TRIG + ((h + a) % DEPTH)];
    endfunction

    function automatic logic [7:0] gen_data(input int mode, input int base, input int n);
        case (mode)
            0:       return 8'((base + n) % 256);
            1:       return 8'($urandom_range(255));
            default: return 8'd0;
        endcase
    endfunction

    // ---------------- read scoreboard ----------------
    typedef struct {
        int         addr;
        logic [7:0] data;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    logic    rd_req = 1'b0;
    logic    rd_vld = 1'b0;

    always @(posedge clk) rd_vld <= rd_req;

    always @(negedge clk) begin
        if (rd_vld) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_underflow: got data %0d with no expectation queued", wave_rd_data);
            end else begin
                rd_exp_t e;
                e = exp_q.pop_front();
                check($sformatf("rd_addr%0d", e.addr), 32'(wave_rd_data), 32'(e.data));
            end
        end
    end

    task automatic issue_read(input int a, input logic [7:0] e);
        rd_exp_t x;
        @(negedge clk);
        wave_rd_addr = 10'(a);
        rd_req       = 1'b1;
        x.addr       = a;
        x.data       = e;
        exp_q.push_back(x);
    endtask

    task automatic end_reads();
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic model_reads(input int n, input int h);
        for (int i = 0; i < n; i++) begin
            int a;
            a = $urandom_range(DEPTH - 1);
            issue_read(a, exp_read(a, h));
        end
    endtask

    // ---------------- capture stimulus ----------------
    task automatic start_capture(input int rate, input int edge_sel, input int level, input int hs);
        @(negedge clk);
        deci_rate   = 10'(rate);
        trig_edge   = edge_sel[0];
        trig_level  = 8'(level);
        h_shift     = 10'(hs);
        ad_valid    = 1'b0;
        ram_refresh = 1'b1;
        kept.delete();
        vcount     = 0;
        data_n     = 0;
        trig_found = 1'b0;
        trig_idx   = 0;
        rkeep      = (rate == 0) ? 1 : rate;
        cfg_level  = level;
        cfg_edge   = edge_sel[0];
        @(negedge clk);
        ram_refresh = 1'b0;
        check("start_busy", 32'(capture_busy), 32'd1);
        check("start_done_clear", 32'(capture_done), 32'd0);
    endtask

    // Streams samples until the model predicts completion (or stop_kept kept samples).
    task automatic feed(input int mode, input int base, input int vprob, input int stop_kept,
                        input bit pulse_in_post);
        bit   pulsed;
        bit   fin;
        logic exp_d;
        pulsed = 1'b0;
        fin    = 1'b0;
        for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
            ram_refresh = 1'b0;
            if (pulse_in_post && !pulsed && trig_found && kept.size() > trig_idx + 3) begin
                ram_refresh = 1'b1;
                pulsed      = 1'b1;
            end
            if ($urandom_range(99) < vprob) begin
                ad_valid = 1'b1;
                ad_data  = gen_data(mode, base, data_n);
                data_n++;
                model_push(ad_data);
            end else begin
                ad_valid = 1'b0;
            end
            @(negedge clk);
            exp_d = model_done();
            check("done_flag", 32'(capture_done), 32'(exp_d));
            if (capture_done !== exp_d) fin = 1'b1;
            if (exp_d) begin
                check("done_busy", 32'(capture_busy), 32'd0);
                fin = 1'b1;
            end
            if (stop_kept >= 0 && kept.size() == stop_kept) fin = 1'b1;
        end
        ad_valid    = 1'b0;
        ram_refresh = 1'b0;
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL capture_timeout: kept=%0d trig_found=%0d", kept.size(), trig_found);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_rd_data", 32'(wave_rd_data), 32'd0);
        check("rst_done", 32'(capture_done), 32'd0);
        check("rst_busy", 32'(capture_busy), 32'd0);
        rst      = 1'b0;
        wave_run = 1'b1;

        // Ramp rising at 100: trigger on the first armed sample.
        start_capture(1, 1, 100, 0);
        feed(0, 100, 100, -1, 1'b0);
        issue_read(512, 8'd100);
        issue_read(511, 8'd99);
        model_reads(4, 0);
        end_reads();
        h_shift = 10'd1;
        issue_read(511, 8'd100);
        model_reads(3, 1);
        end_reads();

        // Ramp falling at 100: only the 255->0 wrap triggers.
        start_capture(1, 0, 100, 0);
        feed(0, 0, 100, -1, 1'b0);
        issue_read(512, 8'd0);
        issue_read(511, 8'd255);
        model_reads(4, 0);
        end_reads();

        // Decimate by 4 on a counter stream with gaps; consecutive addresses step by 4.
        start_capture(4, 1, 50, 0);
        feed(0, 0, 60, -1, 1'b0);
        for (int a = 500; a < 506; a++) issue_read(a, exp_read(a, 0));
        end_reads();

        // deci_rate 0 keeps every sample.
        start_capture(0, 0, 200, 3);
        feed(0, 37, 70, -1, 1'b0);
        model_reads(6, 3);
        end_reads();

        // wave_run dropped while ARMED, then a fresh refresh restarts.
        start_capture(1, 1, 100, 0);
        feed(2, 0, 100, 600, 1'b0);
        wave_run = 1'b0;
        @(negedge clk);
        check("run_drop_busy", 32'(capture_busy), 32'd0);
        check("run_drop_done", 32'(capture_done), 32'd0);
        wave_run = 1'b1;
        @(negedge clk);
        check("run_back_idle", 32'(capture_busy), 32'd0);
        start_capture(2, 1, 128, 5);
        feed(1, 0, 80, -1, 1'b0);
        model_reads(5, 5);
        end_reads();

        // Refresh during POST ignored; refresh in DONE recaptures.
        start_capture(1, 1, 100, 0);
        feed(0, 100, 100, -1, 1'b1);
        issue_read(512, 8'd100);
        end_reads();
        start_capture(1, 0, 77, 9);
        feed(1, 0, 90, -1, 1'b0);
        model_reads(5, 9);
        end_reads();

        // Reset while in POST aborts the capture and blocks further writes.
        start_capture(1, 1, 100, 0);
        wave_rd_addr = 10'd513;
        feed(0, 100, 100, 600, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_rd_data", 32'(wave_rd_data), 32'd0);
        check("post_rst_done", 32'(capture_done), 32'd0);
        check("post_rst_busy", 32'(capture_busy), 32'd0);
        ad_valid = 1'b1;
        ad_data  = 8'hEE;
        repeat (50) @(negedge clk);
        ad_valid = 1'b0;
        check("post_rst_still_idle", 32'(capture_busy), 32'd0);
        h_shift = 10'd0;
        for (int j = 0; j < 4; j++) issue_read((j + PRE_TRIG) % DEPTH, kept[j]);
        for (int j = 597; j < 600; j++) issue_read((j + PRE_TRIG) % DEPTH, kept[j]);
        end_reads();

        // Randomized captures.
        for (int t = 0; t < 3; t++) begin
            int rate, edge_sel, level, hs;
            rate     = $urandom_range(2);
            edge_sel = $urandom_range(1);
            level    = $urandom_range(254, 1);
            hs       = $urandom_range(DEPTH - 1);
            start_capture(rate, edge_sel, level, hs);
            feed(1, 0, $urandom_range(100, 50), -1, 1'b0);
            model_reads(6, hs);
            end_reads();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
